// File: rtl/ram_loader_if.sv
// ram_loader_if: byte stream (valid/ready) plus program RAM pin bundle.
// master = loader side, slave = stream source + RAM side.
interface ram_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;

  modport master (
    input  in_data, in_valid, ram_q,
    output in_ready, ram_data, ram_addr,
    output ram_we, ram_re
  );

  modport slave (
    output in_data, in_valid, ram_q,
    input  in_ready, ram_data, ram_addr,
    input  ram_we, ram_re
  );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: fills the 16x8 program RAM from a byte stream at addr 0..len-1.
// Ports: clk, rst_n (async low), start/len request, bus (ram_loader_if.master:
//   in_data/in_valid/in_ready stream, ram_data/addr/we/re/q RAM pins),
//   busy, done (pulse), error (sticky verify mismatch), checksum (mod-256).
// Macro RAM_LOADER_VERIFY_EN adds a readback pass compared against checksum.
module ram_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  ram_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = DEPTH[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
`ifdef RAM_LOADER_VERIFY_EN
    S_VERIFY,
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              rdy_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sum_q;
  logic [ADDR_W:0]   len_c;
  logic              last;

  assign len_c = (len > LEN_MAX) ? LEN_MAX : len;
  // len_q is never 0 once out of IDLE, so len_q-1 cannot underflow.
  assign last  = ({1'b0, ptr_q} == len_q - (ADDR_W+1)'(1));

`ifdef RAM_LOADER_VERIFY_EN
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  logic              re_q;
  logic              err_q;
  logic [DATA_W-1:0] rsum_q;
  logic [CW-1:0]     cnt_q;

  assign bus.ram_re = re_q;
  assign error      = err_q;
`else
  logic unused_rd;

  assign unused_rd  = ^bus.ram_q ^ (RD_LAT == 0);
  assign bus.ram_re = 1'b0;
  assign error      = 1'b0;
`endif

  assign bus.in_ready = rdy_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign checksum     = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
`ifdef RAM_LOADER_VERIFY_EN
      re_q    <= 1'b0;
      err_q   <= 1'b0;
      rsum_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q  <= '0;
            busy_q <= 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
            err_q  <= 1'b0;
`endif
            if (len == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              len_q   <= len_c;
              ptr_q   <= '0;
              rdy_q   <= 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            addr_q  <= ptr_q;
            data_q  <= bus.in_data;
            sum_q   <= sum_q + bus.in_data;
            rdy_q   <= 1'b0;
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          we_q <= 1'b0;
          if (last) begin
`ifdef RAM_LOADER_VERIFY_EN
            ptr_q   <= '0;
            addr_q  <= '0;
            rsum_q  <= '0;
            cnt_q   <= '0;
            re_q    <= 1'b1;
            state_q <= S_VERIFY;
`else
            done_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end else begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            rdy_q   <= 1'b1;
            state_q <= S_LOAD;
          end
        end
`ifdef RAM_LOADER_VERIFY_EN
        // Address and re stay put for RD_LAT cycles; q is taken on the last.
        S_VERIFY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            rsum_q <= rsum_q + bus.ram_q;
            if (last) begin
              re_q    <= 1'b0;
              state_q <= S_CHECK;
            end else begin
              ptr_q  <= ptr_q + ADDR_W'(1);
              addr_q <= ptr_q + ADDR_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_CHECK: begin
          err_q   <= (rsum_q != sum_q);
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed + random loads against a queue/array reference.
// Holds a RAM model with optional read corruption of address 1.
module tb_ram_loader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RL = 2;
`ifdef RAM_LOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  ram_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_loader #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .len(len),
    .bus(bus),
    .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       corrupt = 1'b0;
  logic [7:0] q_r = 8'h00;

  assign bus.ram_q = q_r;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    if (bus.ram_re)
      q_r <= (corrupt && bus.ram_addr == 4'd1) ? 8'h07
                                               : mem[bus.ram_addr];
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int re_cnt = 0;
  int both_cnt = 0;
  int wa[$];
  int wd[$];
  int wt[$];
  int ra[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.ram_we) begin
      wa.push_back(int'(bus.ram_addr));
      wd.push_back(int'(bus.ram_data));
      wt.push_back(cyc);
    end
    if (bus.ram_re) begin
      re_cnt++;
      ra.push_back(int'(bus.ram_addr));
    end
    if (bus.ram_we && bus.ram_re) both_cnt++;
    if (done) done_cnt++;
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input int n);
    int rb;
    int ws;
    rb = 0;
    ws = 0;
    for (int i = 0; i < n; i++) begin
      ws += int'(img[i]);
      rb += (corrupt && i == 1) ? 7 : int'(img[i]);
    end
    return VER && ((rb % 256) != (ws % 256));
  endfunction

  task automatic do_load(input logic [AW:0] ln, input int gap,
                         input int rs_at, input int ab_at);
    int   n;
    int   idx;
    int   g;
    int   d0;
    int   a0;
    int   r0;
    int   s;
    logic fire;
    bit   rs_done;
    n = (int'(ln) > 16) ? 16 : int'(ln);
    wa.delete();
    wd.delete();
    wt.delete();
    ra.delete();
    d0 = done_cnt;
    a0 = acc_cnt;
    r0 = re_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len   = ln;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clr", 32'(error), 32'(0));
    chk("busy_on", 32'(busy), 32'(1));
    idx = 0;
    g = 0;
    rs_done = 1'b0;
    while (idx < n && g < 500) begin
      if (ab_at > 0 && wa.size() == ab_at && bus.ram_we) begin
        rst_n = 1'b0;
        break;
      end
      bus.in_valid = ($urandom_range(99) >= gap);
      bus.in_data  = img[idx];
      start = (rs_at > 0 && idx == rs_at && !rs_done);
      if (start) begin
        rs_done = 1'b1;
        len = 5'd2;
      end
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      g++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (ab_at > 0) return;
    g = 0;
    while (done_cnt == d0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt - d0), 32'(1));
    chk("busy_off", 32'(busy), 32'(0));
    chk("we_off", 32'(bus.ram_we), 32'(0));
    chk("n_writes", 32'(wa.size()), 32'(n));
    chk("n_accept", 32'(acc_cnt - a0), 32'(n));
    s = 0;
    for (int i = 0; i < n; i++) s += int'(img[i]);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk("wr_addr", 32'(wa[i]), 32'(i));
      chk("wr_data", 32'(wd[i]), 32'(img[i]));
      chk("ram_img", 32'(mem[i]), 32'(img[i]));
      if (gap == 0 && i > 0)
        chk("wr_gap", 32'(wt[i] - wt[i-1]), 32'(2));
    end
    chk("checksum", 32'(checksum), 32'(s % 256));
    chk("error", 32'(error), 32'(exp_err(n)));
    chk("re_cycles", 32'(re_cnt - r0), 32'(VER ? n * RL : 0));
    for (int k = 0; k < ra.size(); k++)
      chk("rd_addr", 32'(ra[k]), 32'(k / RL));
    chk("we_re_excl", 32'(both_cnt), 32'(0));
  endtask

  initial begin
    int d_before;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl",
        32'({bus.in_ready, bus.ram_we, bus.ram_re, busy, done, error}),
        32'(0));
    chk("rst_bus", 32'({bus.ram_addr, bus.ram_data}), 32'(0));
    chk("rst_sum", 32'(checksum), 32'(0));
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_we", 32'(wa.size()), 32'(0));
    chk("idle_re", 32'(re_cnt), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_rdy", 32'(bus.in_ready), 32'(0));

    img[0] = 8'h11; img[1] = 8'h22;
    img[2] = 8'h33; img[3] = 8'h44;
    do_load(5'd4, 0, 0, 0);
    chk("sum_aa", 32'(checksum), 32'(8'hAA));

    for (int i = 0; i < 16; i++) img[i] = 8'(8'hF0 + i);
    do_load(5'd16, 35, 0, 0);
    chk("sum_78", 32'(checksum), 32'(8'h78));

    do_load(5'd0, 0, 0, 0);

    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255));
    do_load(5'd5, 0, 2, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255));
      do_load(5'($urandom_range(31)), 30, 0, 0);
    end
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255));
    do_load(5'd31, 20, 0, 0);

    corrupt = 1'b1;
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03;
    do_load(5'd3, 0, 0, 0);
    chk("sum_06", 32'(checksum), 32'(8'h06));
    chk("err_bad", 32'(error), 32'(VER));
    corrupt = 1'b0;
    img[0] = 8'h5A;
    do_load(5'd1, 0, 0, 0);

    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255));
    d_before = done_cnt;
    do_load(5'd8, 0, 0, 2);
    #1;
    chk("abort_hit", 32'(rst_n), 32'(0));
    chk("abort_we", 32'(bus.ram_we), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_rdy", 32'(bus.in_ready), 32'(0));
    chk("abort_wr", 32'(wa.size()), 32'(2));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(done_cnt), 32'(d_before));
    chk("abort_m0", 32'(mem[0]), 32'(img[0]));
    chk("abort_m1", 32'(mem[1]), 32'(img[1]));

    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255));
    do_load(5'd3, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Bus initiator that fills the 16x8 program RAM from a byte stream before the CPU runs.
- Accepts bytes over a valid/ready handshake and issues RAM writes at consecutive addresses starting at 0.
- Optionally reads the image back and checks it against a running 8-bit checksum.
- Sits between the front-panel/serial byte source and the RAM's data/addr/we/re/q pins; it drives the RAM only while busy.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 4, RAM address width (depth 2**ADDR_W = 16).
- RD_LAT, 2, RAM read latency in cycles (address and re held stable) before q is valid.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- len  in  ADDR_W+1  number of bytes to load, 0..16; sampled with start.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts the byte this cycle.
- ram_data  out  DATA_W  write data to RAM.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_q  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes (with or without error).
- error  out  1  sticky verify mismatch; cleared by the next accepted start.
- checksum  out  DATA_W  mod-256 sum of bytes written in the current/last load.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, ram_we, ram_re, busy, done, error = 0; ram_addr, ram_data, checksum = 0; pointer = 0.
- All outputs are registered.
- IDLE:
  - start=1 with len=0: clear checksum and error, pulse done the next cycle, never enter LOAD.
  - start=1 with len>0: latch len, clear pointer, checksum and error, go to LOAD.
- LOAD: in_ready=1, ram_we=0.
  - On in_valid&in_ready: ram_addr<=pointer, ram_data<=in_data, checksum<=checksum+in_data (wraps mod 256), go to WRITE.
  - in_valid low: stay; no timeout.
- WRITE: exactly one cycle with ram_we=1, in_ready=0.
  - If pointer==len-1: go to VERIFY (feature enabled) or DONE.
  - Otherwise pointer+1, back to LOAD.
  - Throughput is 1 byte per 2 cycles.
- ram_we and ram_re are never both high. ram_re=0 outside VERIFY.
- DONE: done=1 for one cycle, then IDLE with busy=0.
  - ram_addr, ram_data and checksum hold their last values.
  - ram_we=0.
- start while busy is ignored. in_valid outside LOAD is ignored and no byte is consumed.
- len>16 is clamped to 16.
- The pointer never wraps past len-1; at len=16 the last write is to address 15.
- Reset mid-load: immediate return to IDLE, ram_we drops asynchronously, the partial image is left in RAM, and no done pulse.

Optional Feature:
- Macro: RAM_LOADER_VERIFY_EN.
- Defined:
  - After the last write, enter VERIFY with pointer=0 and readback sum=0.
  - For each address, hold ram_addr=pointer and ram_re=1 for RD_LAT cycles, then sample ram_q into the readback sum.
  - Advance until pointer==len-1.
  - Then compare the readback sum with checksum: on mismatch error<=1. Go to DONE in either case.
  - Verify adds len*RD_LAT+1 cycles.
- Not defined:
  - No VERIFY state; ram_re is tied 0; error is tied 0; WRITE of the last byte goes directly to DONE.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> all outputs 0; after release, no RAM activity for 20 cycles without start.
- Load 4 bytes: start, len=4, stream 0x11,0x22,0x33,0x44 with in_valid held high -> ram_we pulses at addr 0..3 with those values, one write every 2 cycles; checksum=0xAA; done pulses once; busy low afterwards.
- Backpressure and wrap: len=16, bytes 0xF0..0xFF with random in_valid gaps -> 16 writes at addr 0..15 in order; checksum=0x78 (mod-256 wrap); no write while in_valid=0.
- Boundaries: start with len=0 -> done pulse with no ram_we; start pulsed again mid-load -> ignored, load completes normally.
- Verify (macro on): load 0x01,0x02,0x03 with a RAM model that corrupts addr 1 to 0x07 on read -> 3 reads of RD_LAT cycles each; error=1 at done; checksum=0x06; error clears on the next start.
- Reset mid-load: deassert rst_n after the 2nd write of a len=8 load -> ram_we=0 immediately, state IDLE, no done pulse; a fresh start then loads correctly from addr 0.
